// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared field positions, constants and IF/ID state struct
package pipe_pkg;

  localparam int RD_LSB = 0;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZR    = 5'd31;
  localparam logic [31:0]      NOP_INSTR = 32'h0;

  // Widest PC the stage supports; ADDR_W must not exceed this.
  localparam int PC_W = 64;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instruction;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparison
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             id_valid_i,
  input  logic             id_uses_rn_i,
  input  logic             id_uses_b_i,
  input  logic             id_reg2loc_i,
  input  logic [REG_W-1:0] id_rn_i,
  input  logic [REG_W-1:0] id_rm_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             ex_read_enable_i,
  input  logic             ex_reg_write_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             hazard_o
);

  logic [REG_W-1:0] src_b;
  logic             ex_is_load_dest;
  logic             rn_match;
  logic             b_match;

  // A load in EX only matters when it writes a real register (XZR is never a dependency).
  always_comb begin
    src_b           = id_reg2loc_i ? id_rm_i : id_rd_i;
    ex_is_load_dest = ex_read_enable_i & ex_reg_write_i & (ex_rd_i != REG_ZR);
    rn_match        = id_uses_rn_i & (id_rn_i == ex_rd_i);
    b_match         = id_uses_b_i & (src_b == ex_rd_i);
    hazard_o        = id_valid_i & ex_is_load_dest & (rn_match | b_match);
  end

endmodule

// File: rtl/parameterized_register.sv
// rtl/parameterized_register.sv - enabled register with synchronous active-high clear
module parameterized_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear on reset, otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifid_hazard_stage.sv
// rtl/ifid_hazard_stage.sv - IF/ID register with load-use stall, branch flush and perf counters
module ifid_hazard_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  IF_PC,
  input  logic [INSTR_W-1:0] IF_instruction,
  input  logic               IF_valid,
  input  logic               ID_BrTaken,
  input  logic               ID_Reg2Loc,
  input  logic               ID_usesRn,
  input  logic               ID_usesB,
  input  logic               EX_read_enable,
  input  logic               EX_RegWrite,
  input  logic [4:0]         EX_Rd,
  output logic [ADDR_W-1:0]  ID_PC,
  output logic [INSTR_W-1:0] ID_instruction,
  output logic               ID_valid,
  output logic [4:0]         IFID_Rn,
  output logic [4:0]         IFID_Rm,
  output logic [4:0]         IFID_Rd,
  output logic               PC_write_en,
  output logic               BrTaken_gated,
  output logic               ID_bubble,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count
);

  ifid_t            ifid_d;
  ifid_t            ifid_q;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;

  assign ID_PC          = ifid_q.pc[ADDR_W-1:0];
  assign ID_instruction = ifid_q.instruction;
  assign ID_valid       = ifid_q.valid;
  assign IFID_Rn        = ifid_q.instruction[RN_LSB +: REG_W];
  assign IFID_Rm        = ifid_q.instruction[RM_LSB +: REG_W];
  assign IFID_Rd        = ifid_q.instruction[RD_LSB +: REG_W];

  load_use_detect u_detect (
    .id_valid_i       (ifid_q.valid),
    .id_uses_rn_i     (ID_usesRn),
    .id_uses_b_i      (ID_usesB),
    .id_reg2loc_i     (ID_Reg2Loc),
    .id_rn_i          (IFID_Rn),
    .id_rm_i          (IFID_Rm),
    .id_rd_i          (IFID_Rd),
    .ex_read_enable_i (EX_read_enable),
    .ex_reg_write_i   (EX_RegWrite),
    .ex_rd_i          (EX_Rd),
    .hazard_o         (stall)
  );

  // Stall freezes fetch and suppresses redirects; a bubble goes downstream on stall or empty ID.
  always_comb begin
    PC_write_en   = ~stall;
    BrTaken_gated = ID_BrTaken & ~stall & ifid_q.valid;
    ID_bubble     = stall | ~ifid_q.valid;
  end

  // Next IF/ID contents: a taken branch squashes the fetched word, a fetch bubble loads a NOP.
  always_comb begin
    ifid_d.pc = PC_W'(IF_PC);
    if (BrTaken_gated) begin
      ifid_d.instruction = NOP_INSTR;
      ifid_d.valid       = 1'b0;
    end else begin
      ifid_d.instruction = IF_valid ? IF_instruction : NOP_INSTR;
      ifid_d.valid       = IF_valid;
    end
  end

  parameterized_register #(
    .WIDTH ($bits(ifid_t))
  ) u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  // Saturating event counters: stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (BrTaken_gated && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter state with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule
